// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: four-slot TDM receiver that stages samples and publishes whole frames on dout.
// Optional saturating sync-error counter built only when TDM_DEMUX_ERRCNT_EN is defined.
module tdm_demux_1x4 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] dout,
    output logic               dout_valid,
    output logic [1:0]         slot,
    output logic               sync_err,
    output logic [7:0]         err_cnt
);
    logic [1:0]            slot_q, slot_d;
    logic [2:0][WIDTH-1:0] stg_q, stg_d;
    logic [4*WIDTH-1:0]    dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  sync_err_q, sync_err_d;
    logic                  resync, frame_done;

    assign resync     = din_valid && frame_sync && slot_q != 2'd0;
    assign frame_done = din_valid && !resync && slot_q == 2'd3;

    always_comb begin
        for (int k = 0; k < 3; k++)
            stg_d[k] = (din_valid && slot_q == 2'(k)) || (resync && k == 0) ? din : stg_q[k];
        slot_d       = resync ? 2'd1 : din_valid ? slot_q + 2'd1 : slot_q;
        dout_d       = frame_done ? {din, stg_q[2], stg_q[1], stg_q[0]} : dout_q;
        dout_valid_d = frame_done;
        sync_err_d   = resync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            stg_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            stg_q        <= stg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts on the same edge that raises sync_err so both become visible together.
    always_comb begin
        err_cnt_d = (sync_err_d && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign sync_err   = sync_err_q;
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb_tdm_demux_1x4: directed vector table plus randomized traffic against a queue-based frame model.
module tb_tdm_demux_1x4;
    localparam int W = 4;
`ifdef TDM_DEMUX_ERRCNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1, din_valid = 1'b0, frame_sync = 1'b0;
    logic [W-1:0]   din = '0;
    logic [4*W-1:0] dout;
    logic           dout_valid, sync_err;
    logic [1:0]     slot;
    logic [7:0]     err_cnt;

    tdm_demux_1x4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .dout(dout), .dout_valid(dout_valid), .slot(slot), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit use_model = 1'b0;

    logic [W-1:0]   m_q[$];
    logic [4*W-1:0] m_dout = '0;
    bit             m_dv, m_se;
    int             m_err = 0;

    typedef struct {
        bit             r, v, fs;
        logic [W-1:0]   d;
        logic [4*W-1:0] e_dout;
        bit             e_dv;
        logic [1:0]     e_slot;
        bit             e_se;
        int             e_err;
    } vec_t;
    vec_t tv[$];

    function automatic logic [7:0] exp_err(int n);
        return ERR_ON ? 8'(n > 255 ? 255 : n) : 8'd0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(bit r, bit v, bit fs, logic [W-1:0] d);
        rst = r; din_valid = v; frame_sync = fs; din = d;
        @(posedge clk);
        m_dv = 1'b0; m_se = 1'b0;
        if (r) begin
            m_q.delete(); m_dout = '0; m_err = 0;
        end else if (v) begin
            if (fs && m_q.size() != 0) begin
                m_q.delete(); m_q.push_back(d); m_se = 1'b1; m_err++;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    m_dout = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_dv = 1'b1;
                    m_q.delete();
                end
            end
        end
        #1;
        if (use_model) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("dout_valid", 32'(dout_valid), 32'(m_dv));
            chk("slot", 32'(slot), 32'(m_q.size()));
            chk("sync_err", 32'(sync_err), 32'(m_se));
            chk("err_cnt", 32'(err_cnt), 32'(exp_err(m_err)));
        end
    endtask

    task automatic add(bit r, bit v, bit fs, logic [W-1:0] d, logic [4*W-1:0] e_dout,
                       bit e_dv, logic [1:0] e_slot, bit e_se, int e_err);
        vec_t t;
        t.r = r; t.v = v; t.fs = fs; t.d = d; t.e_dout = e_dout;
        t.e_dv = e_dv; t.e_slot = e_slot; t.e_se = e_se; t.e_err = e_err;
        tv.push_back(t);
    endtask

    initial begin
        // continuous stream 1,2,3,4
        add(1,0,0,0, 16'h0000, 0,0,0,0);
        add(0,1,0,1, 16'h0000, 0,1,0,0);
        add(0,1,0,2, 16'h0000, 0,2,0,0);
        add(0,1,0,3, 16'h0000, 0,3,0,0);
        add(0,1,0,4, 16'h4321, 1,0,0,0);
        add(0,0,0,0, 16'h4321, 0,0,0,0);
        // gapped stream, including an unqualified frame_sync mid-frame
        add(1,0,0,0, 16'h0000, 0,0,0,0);
        add(0,1,0,1, 16'h0000, 0,1,0,0);
        add(0,0,0,0, 16'h0000, 0,1,0,0);
        add(0,1,0,2, 16'h0000, 0,2,0,0);
        add(0,0,1,5, 16'h0000, 0,2,0,0);
        add(0,1,0,3, 16'h0000, 0,3,0,0);
        add(0,0,1,15,16'h0000, 0,3,0,0);
        add(0,1,0,4, 16'h4321, 1,0,0,0);
        add(0,0,0,0, 16'h4321, 0,0,0,0);
        // mid-frame resync
        add(1,0,0,0, 16'h0000, 0,0,0,0);
        add(0,1,0,1, 16'h0000, 0,1,0,0);
        add(0,1,0,2, 16'h0000, 0,2,0,0);
        add(0,1,1,9, 16'h0000, 0,1,1,1);
        add(0,1,0,8, 16'h0000, 0,2,0,1);
        add(0,1,0,7, 16'h0000, 0,3,0,1);
        add(0,1,0,6, 16'h6789, 1,0,0,1);
        add(0,0,0,0, 16'h6789, 0,0,0,1);
        // reset mid-frame, then A,B,C,D; then sync at slot 0 and back-to-back resyncs
        add(1,0,0,0, 16'h0000, 0,0,0,0);
        add(0,1,0,1, 16'h0000, 0,1,0,0);
        add(0,1,0,2, 16'h0000, 0,2,0,0);
        add(1,1,0,3, 16'h0000, 0,0,0,0);
        add(0,1,0,10,16'h0000, 0,1,0,0);
        add(0,1,0,11,16'h0000, 0,2,0,0);
        add(0,1,0,12,16'h0000, 0,3,0,0);
        add(0,1,0,13,16'hDCBA, 1,0,0,0);
        add(0,1,1,5, 16'hDCBA, 0,1,0,0);
        add(0,1,1,6, 16'hDCBA, 0,1,1,1);
        add(0,1,1,7, 16'hDCBA, 0,1,1,2);
        // sync landing on slot 3 resyncs instead of completing the frame
        add(0,1,0,8, 16'hDCBA, 0,2,0,2);
        add(0,1,0,9, 16'hDCBA, 0,3,0,2);
        add(0,1,1,1, 16'hDCBA, 0,1,1,3);

        @(negedge clk);
        foreach (tv[i]) begin
            cyc(tv[i].r, tv[i].v, tv[i].fs, tv[i].d);
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tv[i].e_dout));
            chk($sformatf("vec%0d_dv", i), 32'(dout_valid), 32'(tv[i].e_dv));
            chk($sformatf("vec%0d_slot", i), 32'(slot), 32'(tv[i].e_slot));
            chk($sformatf("vec%0d_se", i), 32'(sync_err), 32'(tv[i].e_se));
            chk($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(exp_err(tv[i].e_err)));
        end

        use_model = 1'b1;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 3);
        repeat (300) cyc(0, 1, 1, 4'(m_err));
        chk("err_cnt_saturated", 32'(err_cnt), ERR_ON ? 32'd255 : 32'd0);
        cyc(0, 1, 1, 2);
        chk("err_cnt_no_wrap", 32'(err_cnt), ERR_ON ? 32'd255 : 32'd0);

        cyc(1, 0, 0, 0);
        repeat (3000) begin
            bit r, v, fs;
            r  = $urandom_range(0, 149) == 0;
            v  = $urandom_range(0, 3) != 0;
            fs = $urandom_range(0, 6) == 0;
            cyc(r, v, fs, W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1x4.md
# tdm_demux_1x4

Time-division demultiplexer: the receive-side counterpart of the team's 4:1 multiplexers. Accepts a serialized stream of samples interleaved over four channel slots (slot 0,1,2,3, repeating) and distributes each sample to its channel. Completed frames are presented on four parallel registered outputs with a one-cycle valid strobe. Sits at the far end of a TDM link driven by a select-counter plus 4:1 mux transmitter.

## Interface

Parameters:
- WIDTH, 1: bit width of one channel sample.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  serial sample for the current slot.
- din_valid  input  1  din carries a sample this cycle; no sample otherwise.
- frame_sync  input  1  qualified by din_valid; marks the current sample as slot 0.
- dout  output  4*WIDTH  last completed frame; channel k at dout[k*WIDTH +: WIDTH].
- dout_valid  output  1  one-cycle pulse when dout has just been updated.
- slot  output  2  slot index the next accepted sample will occupy.
- sync_err  output  1  one-cycle pulse on a frame_sync that arrives mid-frame.
- err_cnt  output  8  saturating sync-error count; see Configuration.

## Operation

- State: 2-bit slot counter; staging registers for ch0..ch2; output register dout.
- Accept: a sample is accepted on a rising edge with din_valid=1. Cycles with din_valid=0 change no state, and frame_sync is ignored on those cycles.
- Normal accept, no frame_sync: the sample is written to the staging slot given by the counter. The counter increments mod 4 (3 wraps to 0).
- Accept at slot 3: staging ch0..ch2 plus din (as ch3) are loaded into dout in one step. dout_valid pulses for one cycle. The counter returns to 0.
- frame_sync with din_valid while slot=0: treated as a normal accept.
- frame_sync with din_valid while slot≠0: the partial frame is discarded and dout is left untouched. din is stored as ch0, the counter becomes 1, and sync_err pulses.
- No frame_sync ever asserted: the counter free-runs on accepted samples. Alignment is established by reset.
- dout holds its value between frames. A partial frame is never visible on dout.

## Timing

- Reset values: slot=0, dout=0, dout_valid=0, sync_err=0, err_cnt=0. Staging registers are cleared.
- Reset has priority over every other input on the same edge.
- Reset mid-frame discards the partial frame. The next accepted sample is slot 0.
- Latency: the slot-3 sample accepted at edge N appears on dout after edge N. dout_valid is high for exactly the cycle following edge N.
- Minimum frame period is 4 cycles (din_valid held high), giving back-to-back dout_valid pulses every 4th cycle.
- sync_err asserts in the cycle after the offending edge, one cycle wide. Consecutive offending edges produce consecutive pulses.
- A slot-3 accept and a frame_sync cannot coincide: frame_sync at slot 3 is a mid-frame sync. It follows the resync rule and produces no dout update.

## Configuration

- Macro: TDM_DEMUX_ERRCNT_EN.
- Defined: err_cnt increments by 1 on every sync_err pulse and saturates at 255. It clears only on rst.
- Undefined: err_cnt is tied to 0 and the counter logic is not built. sync_err behaviour is unchanged.

## Test plan

- Reset, then WIDTH=4, din_valid=1 continuously, din=1,2,3,4 -> after the 4th edge: dout=0x4321, dout_valid high for 1 cycle, slot=0.
- Same stream with din_valid=0 inserted between every sample -> identical dout=0x4321. dout_valid pulses once, after the 4th accepted sample. slot steps 0,1,2,3,0 only on accepts.
- Samples 1,2 then frame_sync with din=9, then 8,7,6 -> sync_err pulses once. There is no dout_valid for the partial frame. Then dout=0x6789 with a dout_valid pulse. err_cnt=1 if the macro is defined, 0 if undefined.
- 300 mid-frame frame_sync events with TDM_DEMUX_ERRCNT_EN defined -> err_cnt saturates at 255, with no wrap.
- rst asserted after 2 accepted samples, then samples A,B,C,D -> dout=0xDCBA. No earlier data leaks; dout was 0 until this frame.
- frame_sync asserted with din_valid=0 mid-frame -> no sync_err and the slot counter is unchanged.
